matrix_alu_seq: RTL and testbench

Sequential, parametrised matrix ALU for the matrix coprocessor datapath. It latches two square signed matrices plus a scalar on a start handshake and computes one of six operations element by element into a result register. It reports done, busy, sticky overflow and error. It serves as the generalised, multi-cycle successor to the combinational operation selector, with configurable element width and maximum dimension.

---
 rtl/matrix_alu_seq.sv | 218 +++++++++++++++++++++
 tb/tb_matrix_alu_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_alu_seq.sv
// -----------------------------------------------------------------------------
// matrix_alu_seq
//   Sequential matrix ALU. On an accepted start it latches two square signed
//   matrices plus a scalar, then computes one result element per written cycle
//   into result_final:
//     000 A+B   001 A-B   010 transpose(A)   011 -A   100 scalar*A   101 A*B
//   Element-wise ops take N*N RUN cycles. A*B takes N*N*N RUN cycles, one MAC
//   per cycle. Invalid requests go straight to DONE with error set.
//
// Parameters
//   ELEM_W  signed element width (4..16)
//   MAX_N   maximum matrix dimension (2..8)
//   SIZE_W  width of matrix_size (derived)
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           request pulse, accepted only when idle
//   op_code         operation select (110/111 invalid)
//   matrix_size     dimension N, valid 1..MAX_N
//   matrix_a/_b     element (r,c) at [(r*MAX_N+c)*ELEM_W +: ELEM_W]
//   scalar          multiplier for op 100
//   result_final    result register, same layout as the inputs
//   busy            high from acceptance through the DONE cycle
//   process_done    one-cycle completion pulse
//   overflow        sticky: some element did not fit in ELEM_W
//   error           invalid op_code or matrix_size
//
// Build option
//   MATRIX_ALU_SAT_EN  defined: out-of-range elements clamp to the ELEM_W
//                      limits. Undefined: they wrap (low ELEM_W bits kept).
// -----------------------------------------------------------------------------
module matrix_alu_seq #(
   parameter int ELEM_W = 8,
   parameter int MAX_N  = 5,
   parameter int SIZE_W = $clog2(MAX_N + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [2:0]                    op_code,
   input  logic [SIZE_W-1:0]             matrix_size,
   input  logic [MAX_N*MAX_N*ELEM_W-1:0] matrix_a,
   input  logic [MAX_N*MAX_N*ELEM_W-1:0] matrix_b,
   input  logic [ELEM_W-1:0]             scalar,
   output logic [MAX_N*MAX_N*ELEM_W-1:0] result_final,
   output logic                          busy,
   output logic                          process_done,
   output logic                          overflow,
   output logic                          error
);

   localparam int MAT_W = MAX_N * MAX_N * ELEM_W;
   // Wide enough for an N-term sum of full ELEM_W x ELEM_W products.
   localparam int ACC_W = 2 * ELEM_W + $clog2(MAX_N);
   localparam int IDX_W = $clog2(MAX_N);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_TRN = 3'd2;
   localparam logic [2:0] OP_NEG = 3'd3;
   localparam logic [2:0] OP_SCL = 3'd4;
   localparam logic [2:0] OP_MUL = 3'd5;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state_q, state_d;

   // Latched request
   logic [2:0]               op_q;
   logic [IDX_W-1:0]         last_q;   // N-1
   logic [MAT_W-1:0]         a_q, b_q;
   logic signed [ELEM_W-1:0] s_q;

   // Iteration state
   logic [IDX_W-1:0]         row_q, col_q, k_q;
   logic signed [ACC_W-1:0]  acc_q;

   logic signed [ELEM_W-1:0] a_m   [MAX_N][MAX_N];
   logic signed [ELEM_W-1:0] b_m   [MAX_N][MAX_N];
   logic signed [ELEM_W-1:0] res_m [MAX_N][MAX_N];

   logic ovf_q, err_q;

   // Datapath combinational results
   logic                     req_bad;
   logic signed [ACC_W-1:0]  mac;
   logic signed [ACC_W-1:0]  full;
   logic [ACC_W-ELEM_W:0]    hi;
   logic                     elem_ovf;
   logic signed [ELEM_W-1:0] narrowed;
   logic                     wr_en;
   logic                     last_elem;

   // Flat buses <-> element arrays
   for (genvar i = 0; i < MAX_N; i++) begin : g_row
      for (genvar j = 0; j < MAX_N; j++) begin : g_col
         assign a_m[i][j] = a_q[(i*MAX_N+j)*ELEM_W +: ELEM_W];
         assign b_m[i][j] = b_q[(i*MAX_N+j)*ELEM_W +: ELEM_W];
         assign result_final[(i*MAX_N+j)*ELEM_W +: ELEM_W] = res_m[i][j];
      end
   end

   function automatic logic signed [ACC_W-1:0] sx(input logic signed [ELEM_W-1:0] x);
      return ACC_W'(x);
   endfunction

   assign req_bad = (op_code > OP_MUL) || (matrix_size == '0) ||
                    (matrix_size > SIZE_W'(MAX_N));

   always_comb begin
      mac = acc_q + sx(a_m[row_q][k_q]) * sx(b_m[k_q][col_q]);
      case (op_q)
         OP_ADD:  full = sx(a_m[row_q][col_q]) + sx(b_m[row_q][col_q]);
         OP_SUB:  full = sx(a_m[row_q][col_q]) - sx(b_m[row_q][col_q]);
         OP_TRN:  full = sx(a_m[col_q][row_q]);
         OP_NEG:  full = -sx(a_m[row_q][col_q]);
         OP_SCL:  full = sx(s_q) * sx(a_m[row_q][col_q]);
         OP_MUL:  full = mac;
         default: full = '0;
      endcase

      // Fits in ELEM_W iff every bit from the ELEM_W sign bit upward agrees.
      hi       = full[ACC_W-1:ELEM_W-1];
      elem_ovf = !((&hi) || !(|hi));
`ifdef MATRIX_ALU_SAT_EN
      if (elem_ovf)
         narrowed = full[ACC_W-1] ? {1'b1, {(ELEM_W-1){1'b0}}}
                                  : {1'b0, {(ELEM_W-1){1'b1}}};
      else
         narrowed = full[ELEM_W-1:0];
`else
      narrowed = full[ELEM_W-1:0];
`endif

      // A*B only writes once the inner index has covered 0..N-1.
      wr_en     = (op_q != OP_MUL) || (k_q == last_q);
      last_elem = wr_en && (row_q == last_q) && (col_q == last_q);
   end

   // FSM
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = req_bad ? DONE : RUN;
         RUN:  if (last_elem) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= '0;
         last_q <= '0;
         a_q    <= '0;
         b_q    <= '0;
         s_q    <= '0;
         row_q  <= '0;
         col_q  <= '0;
         k_q    <= '0;
         acc_q  <= '0;
         ovf_q  <= 1'b0;
         err_q  <= 1'b0;
         for (int i = 0; i < MAX_N; i++)
            for (int j = 0; j < MAX_N; j++)
               res_m[i][j] <= '0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               op_q   <= op_code;
               last_q <= IDX_W'(matrix_size - 1'b1);
               a_q    <= matrix_a;
               b_q    <= matrix_b;
               s_q    <= scalar;
               row_q  <= '0;
               col_q  <= '0;
               k_q    <= '0;
               acc_q  <= '0;
               ovf_q  <= 1'b0;
               err_q  <= req_bad;
               for (int i = 0; i < MAX_N; i++)
                  for (int j = 0; j < MAX_N; j++)
                     res_m[i][j] <= '0;
            end
            RUN: begin
               if (wr_en) begin
                  res_m[row_q][col_q] <= narrowed;
                  if (elem_ovf) ovf_q <= 1'b1;
                  acc_q <= '0;
                  k_q   <= '0;
                  if (col_q == last_q) begin
                     col_q <= '0;
                     row_q <= row_q + 1'b1;
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end else begin
                  acc_q <= mac;
                  k_q   <= k_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy         = (state_q != IDLE);
   assign process_done = (state_q == DONE);
   assign overflow     = ovf_q;
   assign error        = err_q;

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Scoreboard bench for matrix_alu_seq. Two instances: default parameters
// (ELEM_W=8, MAX_N=5) and a wide one (ELEM_W=12, MAX_N=8). Each issued request
// pushes its hand-computed expected result, flags, completion cycle and busy
// length; a per-instance monitor pops and compares on process_done.
module tb_matrix_alu_seq;

   localparam int W1 = 8,  N1 = 5, M1 = N1*N1*W1, SW1 = $clog2(N1+1);
   localparam int W2 = 12, N2 = 8, M2 = N2*N2*W2, SW2 = $clog2(N2+1);

   typedef logic [767:0] mat_t;
   typedef struct {
      mat_t  res;
      logic  ovf;
      logic  err;
      int    cyc;
      int    blen;
      string nm;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic           start1 = 0, start2 = 0;
   logic [2:0]     op1 = 0, op2 = 0;
   logic [SW1-1:0] sz1 = 0;
   logic [SW2-1:0] sz2 = 0;
   logic [M1-1:0]  a1 = 0, b1 = 0, res1;
   logic [M2-1:0]  a2 = 0, b2 = 0, res2;
   logic [W1-1:0]  s1 = 0;
   logic [W2-1:0]  s2 = 0;
   logic busy1, done1, ovf1, err1, busy2, done2, ovf2, err2;

   matrix_alu_seq #(.ELEM_W(W1), .MAX_N(N1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .op_code(op1), .matrix_size(sz1),
      .matrix_a(a1), .matrix_b(b1), .scalar(s1), .result_final(res1),
      .busy(busy1), .process_done(done1), .overflow(ovf1), .error(err1));

   matrix_alu_seq #(.ELEM_W(W2), .MAX_N(N2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .op_code(op2), .matrix_size(sz2),
      .matrix_a(a2), .matrix_b(b2), .scalar(s2), .result_final(res2),
      .busy(busy2), .process_done(done2), .overflow(ovf2), .error(err2));

   exp_t q1[$], q2[$];
   int n_tests = 0, n_fail = 0;

   function automatic mat_t put(mat_t v, int w, int mx, int r, int c, int val);
      mat_t t = v;
      for (int b = 0; b < w; b++) t[(r*mx+c)*w+b] = val[b];
      return t;
   endfunction
   function automatic mat_t p8(mat_t v, int r, int c, int val);
      return put(v, W1, N1, r, c, val);
   endfunction
   function automatic mat_t p12(mat_t v, int r, int c, int val);
      return put(v, W2, N2, r, c, val);
   endfunction

   task automatic chk_v(string nm, mat_t act, mat_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_i(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic check_done(exp_t e, mat_t act, logic o, logic er, int bc);
      chk_v({e.nm, "_result"}, act, e.res);
      chk_i({e.nm, "_overflow"}, 32'(o), 32'(e.ovf));
      chk_i({e.nm, "_error"}, 32'(er), 32'(e.err));
      chk_i({e.nm, "_done_cycle"}, cyc, e.cyc);
      chk_i({e.nm, "_busy_len"}, bc, e.blen);
   endtask

   // Monitors
   int bc1 = 0, bc2 = 0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) bc1 = 0;
      else begin
         if (busy1) bc1++;
         if (done1) begin
            if (q1.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL dut1_unexpected_done: got done at cycle %0d want none", cyc);
            end else begin
               e = q1.pop_front();
               check_done(e, {{(768-M1){1'b0}}, res1}, ovf1, err1, bc1);
            end
            bc1 = 0;
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) bc2 = 0;
      else begin
         if (busy2) bc2++;
         if (done2) begin
            if (q2.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL dut2_unexpected_done: got done at cycle %0d want none", cyc);
            end else begin
               e = q2.pop_front();
               check_done(e, res2, ovf2, err2, bc2);
            end
            bc2 = 0;
         end
      end
   end

   // Waits for the selected instance to be idle, issues one request and
   // records what its completion must look like. Called at posedge+#1.
   task automatic issue(int sel, logic [2:0] op, int n, mat_t a, mat_t b, int s,
                        mat_t eres, logic eo, logic ee, int lat, string nm);
      exp_t e;
      int g = 0;
      while (((sel == 1) ? busy1 : busy2) !== 1'b0 && g < 2000) begin
         @(posedge clk); #1; g++;
      end
      if (g >= 2000) begin
         n_tests++; n_fail++;
         $display("FAIL %s_idle_wait: got busy after %0d cycles want idle", nm, g);
      end
      if (sel == 1) begin
         op1 = op; sz1 = SW1'(n); a1 = a[M1-1:0]; b1 = b[M1-1:0]; s1 = W1'(s);
         start1 = 1'b1;
      end else begin
         op2 = op; sz2 = SW2'(n); a2 = a[M2-1:0]; b2 = b[M2-1:0]; s2 = W2'(s);
         start2 = 1'b1;
      end
      @(posedge clk); #1;
      start1 = 1'b0; start2 = 1'b0;
      e.res = eres; e.ovf = eo; e.err = ee;
      e.cyc = cyc + lat; e.blen = lat + 1; e.nm = nm;
      if (sel == 1) q1.push_back(e); else q2.push_back(e);
   endtask

   initial begin
      mat_t a, b, e, a5, b5;
      int g;

      repeat (3) @(posedge clk);
      #1;
      chk_v("rst_result1", {{(768-M1){1'b0}}, res1}, '0);
      chk_i("rst_busy1", 32'(busy1), 0);
      chk_i("rst_done1", 32'(done1), 0);
      chk_i("rst_ovf1", 32'(ovf1), 0);
      chk_i("rst_err1", 32'(err1), 0);
      chk_v("rst_result2", res2, '0);
      chk_i("rst_busy2", 32'(busy2), 0);
      chk_i("rst_err2", 32'(err2), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Add / sub, N=2, with junk outside the 2x2 region
      a = '0; b = '0;
      a = p8(a,0,0,1);  a = p8(a,0,1,2);  a = p8(a,1,0,3);  a = p8(a,1,1,4);  a = p8(a,2,2,5);
      b = p8(b,0,0,10); b = p8(b,0,1,20); b = p8(b,1,0,30); b = p8(b,1,1,40); b = p8(b,4,4,9);
      e = '0; e = p8(e,0,0,11); e = p8(e,0,1,22); e = p8(e,1,0,33); e = p8(e,1,1,44);
      issue(1, 3'b000, 2, a, b, 0, e, 0, 0, 4, "add_n2");
      e = '0; e = p8(e,0,0,-9); e = p8(e,0,1,-18); e = p8(e,1,0,-27); e = p8(e,1,1,-36);
      issue(1, 3'b001, 2, a, b, 0, e, 0, 0, 4, "sub_n2");

      // Multiply N=2: [1,2;3,4]*[5,6;7,8]
      a = '0; b = '0;
      a = p8(a,0,0,1); a = p8(a,0,1,2); a = p8(a,1,0,3); a = p8(a,1,1,4); a = p8(a,3,3,77);
      b = p8(b,0,0,5); b = p8(b,0,1,6); b = p8(b,1,0,7); b = p8(b,1,1,8);
      e = '0; e = p8(e,0,0,19); e = p8(e,0,1,22); e = p8(e,1,0,43); e = p8(e,1,1,50);
      issue(1, 3'b101, 2, a, b, 0, e, 0, 0, 8, "mul_n2");

      // Multiply N=3: identity * [1..9]
      a = '0; b = '0;
      for (int r = 0; r < 3; r++) begin
         a = p8(a, r, r, 1);
         for (int c = 0; c < 3; c++) b = p8(b, r, c, r*3 + c + 1);
      end
      issue(1, 3'b101, 3, a, b, 0, b, 0, 0, 27, "mul_ident_n3");

      // Overflow, N=1
      a = p8('0,0,0,100); b = p8('0,0,0,100);
`ifdef MATRIX_ALU_SAT_EN
      e = p8('0,0,0,127);
`else
      e = p8('0,0,0,-56);
`endif
      issue(1, 3'b000, 1, a, b, 0, e, 1, 0, 1, "add_ovf");
      a = p8('0,0,0,-128);
`ifdef MATRIX_ALU_SAT_EN
      e = p8('0,0,0,127);
`else
      e = p8('0,0,0,-128);
`endif
      issue(1, 3'b011, 1, a, '0, 0, e, 1, 0, 1, "neg_min");

      // Invalid requests
      a = p8('0,0,0,3);
      issue(1, 3'b111, 2, a, a, 0, '0, 0, 1, 0, "bad_op");
      issue(1, 3'b000, 0, a, a, 0, '0, 0, 1, 0, "bad_size0");
      issue(1, 3'b000, N1+1, a, a, 0, '0, 0, 1, 0, "bad_size_big");

      // N=5 multiply, with an ignored start and changed inputs mid-run
      a5 = '0; b5 = '0;
      for (int r = 0; r < 5; r++) begin
         a5 = p8(a5, r, r, 1);
         for (int c = 0; c < 5; c++) b5 = p8(b5, r, c, r*5 + c - 12);
      end
      issue(1, 3'b101, 5, a5, b5, 0, b5, 0, 0, 125, "mul_n5_busy");
      repeat (5) @(posedge clk);
      #1;
      chk_i("busy_mid_run", 32'(busy1), 1);
      start1 = 1'b1; op1 = 3'b000; sz1 = 2; a1 = '1; b1 = '1;
      @(posedge clk); #1;
      start1 = 1'b0;

      // Reset in the middle of an N=5 multiply
      issue(1, 3'b101, 5, a5, b5, 0, b5, 0, 0, 125, "mul_n5_rst");
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk_i("midrst_busy", 32'(busy1), 0);
      chk_i("midrst_done", 32'(done1), 0);
      chk_i("midrst_ovf", 32'(ovf1), 0);
      chk_v("midrst_result", {{(768-M1){1'b0}}, res1}, '0);
      q1.delete();
      rst = 1'b0;
      @(posedge clk); #1;
      a = '0; b = '0;
      a = p8(a,0,0,1);  a = p8(a,0,1,2);  a = p8(a,1,0,3);  a = p8(a,1,1,4);
      b = p8(b,0,0,10); b = p8(b,0,1,20); b = p8(b,1,0,30); b = p8(b,1,1,40);
      e = '0; e = p8(e,0,0,11); e = p8(e,0,1,22); e = p8(e,1,0,33); e = p8(e,1,1,44);
      issue(1, 3'b000, 2, a, b, 0, e, 0, 0, 4, "add_after_rst");

      // Wide instance: transpose N=4, then scalar -2
      a = '0; e = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            a = p12(a, r, c, r*4 + c + 1);
            e = p12(e, r, c, c*4 + r + 1);
         end
      a = p12(a, 5, 5, 99);
      issue(2, 3'b010, 4, a, p12('0,0,0,3), 0, e, 0, 0, 16, "transpose_n4");
      a = p12(a, 0, 0, 1024);
      e = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            e = p12(e, r, c, -2 * ((r == 0 && c == 0) ? 1024 : r*4 + c + 1));
      issue(2, 3'b100, 4, a, '0, -2, e, 0, 0, 16, "scalar_m2_n4");
      a = p12('0,0,0,-1024);
`ifdef MATRIX_ALU_SAT_EN
      e = p12('0,0,0,2047);
`else
      e = p12('0,0,0,-2048);
`endif
      issue(2, 3'b100, 1, a, '0, -2, e, 1, 0, 1, "scalar_ovf");

      g = 0;
      while ((q1.size() != 0 || q2.size() != 0) && g < 5000) begin
         @(posedge clk); #1; g++;
      end
      if (g >= 5000) begin
         n_tests++; n_fail++;
         $display("FAIL drain: got %0d/%0d pending want 0/0", q1.size(), q2.size());
      end
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
